// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline sequencer for the 5-stage RV32I core.
// Generates PC enable/redirect and per-stage stall/flush strobes from reset
// priming, data-memory waits, MEM-stage redirects and load-use hazards.
// Optional macro HAZARD_PERF_CNT_EN adds stall/redirect performance counters;
// without it stall_cnt and flush_cnt are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | priming after reset, PC held and every stage flushed
// RUN      | normal flow, redirect and load-use resolution
// MEM_WAIT | data memory busy, front end frozen, WB fed bubbles
module hazard_control_unit #(
  parameter int ADDR_SIZE  = 10,
  parameter int REG_SEL    = 5,
  parameter int RESET_HOLD = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SEL-1:0]   rs1_id,
  input  logic [REG_SEL-1:0]   rs2_id,
  input  logic                 use_rs1_id,
  input  logic                 use_rs2_id,
  input  logic [REG_SEL-1:0]   rd_ex,
  input  logic                 mem_read_ex,
  input  logic                 redirect_mem,
  input  logic [ADDR_SIZE-1:0] target_mem,
  input  logic                 mem_busy,
  output logic                 pc_en,
  output logic                 pc_src,
  output logic [ADDR_SIZE-1:0] redirect_pc,
  output logic                 stall_ifid,
  output logic                 stall_idex,
  output logic                 stall_exmem,
  output logic                 stall_memwb,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 flush_exmem,
  output logic                 flush_memwb,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              lu;

  // x0 is never a real producer, so it cannot create a hazard.
  assign lu = mem_read_ex && (rd_ex != '0) &&
              ((use_rs1_id && (rd_ex == rs1_id)) ||
               (use_rs2_id && (rd_ex == rs2_id)));

  // State and priming counter; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      hold_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) state <= RUN;
        end
        RUN:      if (mem_busy) state <= MEM_WAIT;
        MEM_WAIT: if (!mem_busy) state <= RUN;
        default:  state <= INIT;
      endcase
    end
  end

  // Output decode: busy > redirect > load-use; MEM_WAIT falls through to
  // RUN rules in the cycle the memory finishes.
  always_comb begin
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    redirect_pc = '0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (state == INIT) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (mem_busy) begin
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      // Bubble into WB so the stalled MEM instruction writes back once.
      flush_memwb = 1'b1;
    end else if (redirect_mem) begin
      pc_en       = 1'b1;
      pc_src      = 1'b1;
      redirect_pc = target_mem;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (lu) begin
      stall_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;

  // Stall cycles outside priming and redirect events, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (state != INIT)) stall_q <= stall_q + 1'b1;
      if (pc_src) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
